// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: occupancy encoding,
// the NOP control value and the default field widths.
package pipe_pkg;

   localparam int DEF_CTRL_W = 4;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_W   = 5;

   localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = {DEF_CTRL_W{1'b0}};

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle between two pipeline stages; the stage
// register sits on the slave side, the surrounding logic on the master side.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_W   = DEF_RD_W
) ();

   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] ctrl_i;
   logic [DATA_W-1:0] addr_i;
   logic [DATA_W-1:0] data_i;
   logic [RD_W-1:0]   rd_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] ctrl_o;
   logic [DATA_W-1:0] addr_o;
   logic [DATA_W-1:0] data_o;
   logic [RD_W-1:0]   rd_o;
   logic [1:0]        occ_o;

   modport master (
      output in_valid_i, ctrl_i, addr_i, data_i, rd_i, out_ready_i,
      input  in_ready_o, out_valid_o, ctrl_o, addr_o, data_o, rd_o, occ_o
   );

   modport slave (
      input  in_valid_i, ctrl_i, addr_i, data_i, rd_i, out_ready_i,
      output in_ready_o, out_valid_o, ctrl_o, addr_o, data_o, rd_o, occ_o
   );

endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a valid bit plus a payload register.
// Clear drops the valid bit only; the payload keeps its last value.
module pipe_slot #(
   parameter int W = 73
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   logic         valid_r;
   logic [W-1:0] pay_r;

   // Valid bit and payload storage with clear taking priority over load
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_r <= 1'b0;
         pay_r   <= {W{1'b0}};
      end else if (clr_i) begin
         valid_r <= 1'b0;
      end else if (load_i) begin
         valid_r <= 1'b1;
         pay_r   <= d_i;
      end
   end

   assign valid_o = valid_r;
   assign q_o     = pay_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush and bubble gating. The main slot drives the outputs; skid holds the newer entry.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W         = DEF_CTRL_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int RD_W           = DEF_RD_W,
   parameter bit ZERO_ON_BUBBLE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   pipe_stage_skid_if.slave bus
);

   localparam int PAY_W = CTRL_W + 2 * DATA_W + RD_W;

   occ_e             occ_r;
   occ_e             occ_nxt_s;
   logic             in_fire_s;
   logic             out_fire_s;
   logic             main_valid_s;
   logic             skid_valid_s;
   logic             main_load_s;
   logic             main_clr_s;
   logic             main_sel_skid_s;
   logic             skid_load_s;
   logic             skid_clr_s;
   logic [PAY_W-1:0] in_pay_s;
   logic [PAY_W-1:0] main_d_s;
   logic [PAY_W-1:0] main_q_s;
   logic [PAY_W-1:0] skid_q_s;
   logic [PAY_W-1:0] out_pay_s;
   logic [CTRL_W-1:0] ctrl_nop_s;

   assign ctrl_nop_s = {CTRL_W{CTRL_NOP[0]}};
   assign in_pay_s   = {bus.ctrl_i, bus.addr_i, bus.data_i, bus.rd_i};
   // Readiness comes straight from the skid valid register, never from out_ready_i
   assign in_fire_s  = bus.in_valid_i & ~skid_valid_s;
   assign out_fire_s = main_valid_s & bus.out_ready_i;
   assign main_d_s   = main_sel_skid_s ? skid_q_s : in_pay_s;

   // Occupancy state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         occ_r <= OCC_EMPTY;
      end else begin
         occ_r <= occ_nxt_s;
      end
   end

   // Next occupancy and slot load/clear controls; flush overrides any transfer
   always_comb begin
      occ_nxt_s       = occ_r;
      main_load_s     = 1'b0;
      main_clr_s      = 1'b0;
      main_sel_skid_s = 1'b0;
      skid_load_s     = 1'b0;
      skid_clr_s      = 1'b0;
      if (flush_i) begin
         occ_nxt_s  = OCC_EMPTY;
         main_clr_s = 1'b1;
         skid_clr_s = 1'b1;
      end else begin
         case (occ_r)
            OCC_EMPTY: begin
               if (in_fire_s) begin
                  occ_nxt_s   = OCC_ONE;
                  main_load_s = 1'b1;
               end else begin
                  occ_nxt_s = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  occ_nxt_s   = OCC_ONE;
                  main_load_s = 1'b1;
               end else if (in_fire_s) begin
                  occ_nxt_s   = OCC_TWO;
                  skid_load_s = 1'b1;
               end else if (out_fire_s) begin
                  occ_nxt_s  = OCC_EMPTY;
                  main_clr_s = 1'b1;
               end else begin
                  occ_nxt_s = OCC_ONE;
               end
            end
            OCC_TWO: begin
               if (out_fire_s) begin
                  occ_nxt_s       = OCC_ONE;
                  main_load_s     = 1'b1;
                  main_sel_skid_s = 1'b1;
                  skid_clr_s      = 1'b1;
               end else begin
                  occ_nxt_s = OCC_TWO;
               end
            end
            default: begin
               occ_nxt_s  = OCC_EMPTY;
               main_clr_s = 1'b1;
               skid_clr_s = 1'b1;
            end
         endcase
      end
   end

   pipe_slot #(.W(PAY_W)) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (main_load_s),
      .clr_i   (main_clr_s),
      .d_i     (main_d_s),
      .valid_o (main_valid_s),
      .q_o     (main_q_s)
   );

   pipe_slot #(.W(PAY_W)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load_s),
      .clr_i   (skid_clr_s),
      .d_i     (in_pay_s),
      .valid_o (skid_valid_s),
      .q_o     (skid_q_s)
   );

   // Bubbles always carry a NOP control field so WB/M enables cannot fire
   generate
      if (ZERO_ON_BUBBLE) begin : g_zero_all
         assign out_pay_s = main_valid_s ? main_q_s : {PAY_W{1'b0}};
      end else begin : g_zero_ctrl
         assign out_pay_s = {(main_valid_s ? main_q_s[PAY_W-1 -: CTRL_W] : ctrl_nop_s),
                             main_q_s[PAY_W-CTRL_W-1:0]};
      end
   endgenerate

   assign bus.ctrl_o      = out_pay_s[PAY_W-1 -: CTRL_W];
   assign bus.addr_o      = out_pay_s[2*DATA_W+RD_W-1 -: DATA_W];
   assign bus.data_o      = out_pay_s[DATA_W+RD_W-1 -: DATA_W];
   assign bus.rd_o        = out_pay_s[RD_W-1:0];
   assign bus.out_valid_o = main_valid_s;
   assign bus.in_ready_o  = ~skid_valid_s;
   assign bus.occ_o       = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: two instances (bubble zeroing on/off)
// share stimulus and are compared against a two-entry FIFO reference.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int CW = 4;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int PW = CW + 2 * DW + RW;

   logic clk_i   = 1'b0;
   logic rst_i   = 1'b1;
   logic flush_i = 1'b0;

   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW)) bz ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW)) bh ();

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .ZERO_ON_BUBBLE(1'b1)) dut_z (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .bus     (bz.slave)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .ZERO_ON_BUBBLE(1'b0)) dut_h (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .bus     (bh.slave)
   );

   always #5 clk_i = ~clk_i;

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] last_pres = '0;
   bit            ready_m   = 1'b1;
   int            errs      = 0;
   int            checks    = 0;

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted entries enter a FIFO of depth two; flush empties it
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         exp_q.delete();
      end else if (flush_i) begin
         exp_q.delete();
      end else if (bz.in_valid_i && ready_m) begin
         exp_q.push_back({bz.ctrl_i, bz.addr_i, bz.data_i, bz.rd_i});
      end
   end

   // Monitor: compares both instances against the FIFO head, pops on consumption
   always @(negedge clk_i) begin
      int            s;
      logic [PW-1:0] front;
      logic [PW-1:0] got_z;
      logic [PW-1:0] got_h;
      if (!rst_i) last_pres = '0;
      s     = exp_q.size();
      front = (s > 0) ? exp_q[0] : '0;
      got_z = {bz.ctrl_o, bz.addr_o, bz.data_o, bz.rd_o};
      got_h = {bh.ctrl_o, bh.addr_o, bh.data_o, bh.rd_o};
      chk("occ_z", PW'(bz.occ_o), PW'(s));
      chk("occ_h", PW'(bh.occ_o), PW'(s));
      chk("in_ready_z", PW'(bz.in_ready_o), PW'(s < 2));
      chk("in_ready_h", PW'(bh.in_ready_o), PW'(s < 2));
      chk("out_valid_z", PW'(bz.out_valid_o), PW'(s > 0));
      chk("out_valid_h", PW'(bh.out_valid_o), PW'(s > 0));
      if (s > 0) begin
         chk("payload_z", got_z, front);
         chk("payload_h", got_h, front);
         last_pres = front;
         if (bz.out_ready_i) void'(exp_q.pop_front());
      end else begin
         chk("bubble_z", got_z, '0);
         chk("bubble_h", got_h, {{CW{1'b0}}, last_pres[PW-CW-1:0]});
      end
      ready_m = (s < 2);
   end

   task automatic drive(input bit v, input logic [PW-1:0] p, input bit ordy, input bit fl);
      bz.in_valid_i  = v;
      bh.in_valid_i  = v;
      {bz.ctrl_i, bz.addr_i, bz.data_i, bz.rd_i} = p;
      {bh.ctrl_i, bh.addr_i, bh.data_i, bh.rd_i} = p;
      bz.out_ready_i = ordy;
      bh.out_ready_i = ordy;
      flush_i        = fl;
   endtask

   task automatic cyc(input bit v, input logic [PW-1:0] p, input bit ordy, input bit fl);
      @(posedge clk_i);
      #1;
      drive(v, p, ordy, fl);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid_z"}, PW'(bz.out_valid_o), '0);
      chk({tag, "_valid_h"}, PW'(bh.out_valid_o), '0);
      chk({tag, "_ready_z"}, PW'(bz.in_ready_o), PW'(1'b1));
      chk({tag, "_ready_h"}, PW'(bh.in_ready_o), PW'(1'b1));
      chk({tag, "_occ_z"}, PW'(bz.occ_o), '0);
      chk({tag, "_occ_h"}, PW'(bh.occ_o), '0);
      chk({tag, "_pay_z"}, {bz.ctrl_o, bz.addr_o, bz.data_o, bz.rd_o}, '0);
      chk({tag, "_pay_h"}, {bh.ctrl_o, bh.addr_o, bh.data_o, bh.rd_o}, '0);
   endtask

   function automatic logic [PW-1:0] mk(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                        input logic [DW-1:0] d, input logic [RW-1:0] r);
      return {c, a, d, r};
   endfunction

   function automatic logic [PW-1:0] rnd_pay();
      return PW'({$urandom(), $urandom(), $urandom()});
   endfunction

   initial begin
      drive(1'b1, mk(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31), 1'b1, 1'b0);
      #1;
      rst_i = 1'b0;
      #1;
      check_reset_state("reset");
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      drive(1'b0, mk(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31), 1'b1, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Back-to-back streaming with the consumer always ready
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, mk(4'h3, 32'h100 + 32'(i), $urandom(), 5'(i)), 1'b1, 1'b0);
      end
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

      // Stall fills the skid slot; outputs hold A while the stall lasts
      cyc(1'b1, mk(4'h5, 32'hA0, 32'hAAAA, 5'd10), 1'b0, 1'b0);
      cyc(1'b1, mk(4'h6, 32'hB0, 32'hBBBB, 5'd11), 1'b0, 1'b0);
      repeat (5) cyc(1'b1, mk(4'h7, 32'hEE, 32'hEEEE, 5'd12), 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Flush while full with a simultaneous input, then flush in ONE with in_fire
      cyc(1'b1, mk(4'h9, 32'hA1, 32'h1, 5'd1), 1'b0, 1'b0);
      cyc(1'b1, mk(4'hA, 32'hB1, 32'h2, 5'd2), 1'b0, 1'b0);
      cyc(1'b1, mk(4'hC, 32'hC0, 32'h3, 5'd3), 1'b0, 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, mk(4'hD, 32'hD0, 32'h4, 5'd4), 1'b0, 1'b0);
      cyc(1'b1, mk(4'hE, 32'hE0, 32'h5, 5'd5), 1'b1, 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

      // Bubble gating while empty with a live-looking control field on the input
      repeat (3) cyc(1'b0, mk(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31), 1'b0, 1'b0);

      // Randomised traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, rnd_pay(), $urandom_range(0, 2) != 0,
             $urandom_range(0, 31) == 0);
      end
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset asserted between clock edges while full
      cyc(1'b1, mk(4'h1, 32'h51, 32'h61, 5'd7), 1'b0, 1'b0);
      cyc(1'b1, mk(4'h2, 32'h52, 32'h62, 5'd8), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("pre_reset_occ", PW'(bz.occ_o), PW'(2'd2));
      #1;
      rst_i = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, rnd_pay(), 1'b1, 1'b0);
      end
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register; successor to the fixed-width EX/MEM-style latches.
- Carries control, address, data and destination-register fields between two pipeline stages.
- Adds a valid/ready handshake, a one-entry skid buffer for full-throughput stalls, flush with bubble insertion, and an occupancy indication.
- Instantiated between EX and MEM, MEM and WB, and wherever the hazard unit needs stall/flush control.

Parameters:
- CTRL_W, 4, width of the packed control field (WB and M bits).
- DATA_W, 32, width of the addr and data fields.
- RD_W, 5, width of the destination register index.
- ZERO_ON_BUBBLE, 1, when 1, payload outputs are driven to 0 whenever out_valid_o=0; when 0, only ctrl_o is zeroed.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous flush; discards all held entries.
- in_valid_i  input  1  upstream presents a valid entry.
- in_ready_o  output  1  stage can accept an entry this cycle (registered).
- ctrl_i  input  CTRL_W  control bits in.
- addr_i  input  DATA_W  ALU result / address in.
- data_i  input  DATA_W  store data in.
- rd_i  input  RD_W  destination register in.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  downstream consumes the entry this cycle.
- ctrl_o  output  CTRL_W  control bits out; 0 (NOP) when invalid.
- addr_o  output  DATA_W  address out.
- data_o  output  DATA_W  store data out.
- rd_o  output  RD_W  destination register out.
- occ_o  output  2  number of held entries (0, 1 or 2).

Behaviour:
- Storage: main slot drives the outputs; skid slot holds the newer entry. Each slot has its own valid bit.
- Reset (rst_i=0, asynchronous): both valid bits cleared; all payload registers 0; out_valid_o=0, in_ready_o=1, occ_o=0, ctrl_o=0.
- Transfer definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Latency: an accepted entry appears at the outputs the cycle after in_fire when the stage was EMPTY, or when ONE with out_fire in the same cycle.
- States, encoded by occupancy:
  - EMPTY (occ 0): in_fire -> ONE; main <= input.
  - ONE (occ 1):
    - in_fire & out_fire -> ONE; main <= input.
    - in_fire & !out_fire -> TWO; skid <= input.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO (occ 2): in_ready_o=0, so no in_fire.
    - out_fire -> ONE; main <= skid; skid valid cleared.
    - otherwise hold.
- in_ready_o = !skid_valid, taken from a register (no combinational path from out_ready_i).
- out_valid_o = main_valid. Outputs are registered only, with no combinational path from any input.
- Ordering: strict FIFO. The skid entry is never presented ahead of the main entry.
- Stability: while out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- Flush:
  - flush_i=1 at a clock edge -> EMPTY: both valid bits cleared, in_ready_o=1 next cycle.
  - Flush has priority over a same-cycle in_fire; that entry is discarded. Upstream may still see in_ready_o=1 during that cycle; the entry is dropped by design.
- Bubble:
  - ctrl_o is 0 whenever out_valid_o=0, so downstream WB/M enables never fire on a bubble.
  - Other payload outputs are also forced to 0 when ZERO_ON_BUBBLE=1.
- Reset asserted mid-operation: immediate return to the reset values, regardless of occupancy or pending handshakes.
- Widths: all fields are passed through bit-exact; no arithmetic is performed.

Decomposition:
- Shared package pipe_pkg:
  - OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - CTRL_NOP constant (all zeros).
  - Default widths CTRL_W/DATA_W/RD_W.
- Sub-module pipe_slot:
  - One valid bit plus a payload register of width CTRL_W+2*DATA_W+RD_W.
  - Ports: load enable, clear, async reset.
  - Instantiated twice, as main and skid.
- The top level holds the occupancy FSM and output gating.

Test Plan:
- Reset: drive inputs non-zero, rst_i=0 -> out_valid_o=0, ctrl_o=0, addr_o=0, in_ready_o=1, occ_o=0; release reset -> state unchanged until the first in_fire.
- Streaming: out_ready_i=1, 8 back-to-back entries with addr=0x100+i -> each appears 1 cycle later in order; in_ready_o stays 1; occ_o=1 throughout.
- Stall/skid:
  - Entry A (addr 0xA0) then B (addr 0xB0) with out_ready_i=0 -> occ_o=2, in_ready_o=0; outputs hold A for 5 stall cycles.
  - Then out_ready_i=1 -> A consumed, B presented next cycle, then in_ready_o=1.
- Flush in TWO with a simultaneous input C -> next cycle out_valid_o=0, ctrl_o=0, occ_o=0; C never appears at the outputs.
- Bubble gating: ZERO_ON_BUBBLE=1, stage EMPTY with ctrl_i=4'hF and in_valid_i=0 -> ctrl_o=0, data_o=0; with ZERO_ON_BUBBLE=0, data_o holds its last value while ctrl_o=0.
- Async reset asserted mid-cycle while in TWO -> outputs zero immediately, without waiting for a clock edge.
